// File: rtl/node_mem_pkg.sv
// Shared defaults and helpers for the node memory arbiter and its picker.
package node_mem_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int NODE_W_DEF = 12;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_t;

   function automatic int bus_offset(input int port, input int width);
      return port * width;
   endfunction

   // Both operands are already below n, so one conditional subtract wraps correctly.
   function automatic int wrap_add(input int base, input int off, input int n);
      int sum;
      sum = base + off;
      return (sum >= n) ? sum - n : sum;
   endfunction

endpackage

// File: rtl/node_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, skipping
// excluded ports unless nothing else is requesting.
module rr_pick
   import node_mem_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   input  logic [N_PORTS-1:0] exclude,
   output logic [N_PORTS-1:0] winner_oh,
   output logic [IDX_W-1:0]   winner_idx,
   output logic               valid
);

   logic [N_PORTS-1:0] pool;
   logic [IDX_W-1:0]   scan_idx;

   assign pool = ((req & ~exclude) != '0) ? (req & ~exclude) : req;

   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      valid      = 1'b0;
      scan_idx   = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         scan_idx = IDX_W'(wrap_add(int'(rr_ptr), i, N_PORTS));
         if (!valid && pool[scan_idx]) begin
            valid               = 1'b1;
            winner_idx          = scan_idx;
            winner_oh[scan_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/node_mem_arbiter.sv
// N-port round-robin arbiter with bounded lock in front of the node memory.
//   state    | meaning
//   ST_IDLE  | no owner, all mem_* driven to zero
//   ST_OWNED | owner_q holds the memory, mem_* follow that port
module node_mem_arbiter
   import node_mem_pkg::*;
#(
   parameter int N_PORTS  = 2,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NODE_W   = NODE_W_DEF,
   parameter int MAX_LOCK = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_PORTS-1:0]          req,
   input  logic [N_PORTS-1:0]          lock,
   input  logic [N_PORTS*ADDR_W-1:0]   port_read_addr,
   input  logic [N_PORTS*ADDR_W-1:0]   port_write_addr,
   input  logic [N_PORTS-1:0]          port_write,
   input  logic [N_PORTS*NODE_W-1:0]   port_write_node,
   output logic [N_PORTS-1:0]          grant,
   output logic [N_PORTS-1:0]          read_valid,
   output logic [NODE_W-1:0]           read_node,
   output logic [ADDR_W-1:0]           mem_read_addr,
   output logic [ADDR_W-1:0]           mem_write_addr,
   output logic                        mem_write,
   output logic [NODE_W-1:0]           mem_write_node,
   input  logic [NODE_W-1:0]           mem_read_node
);

   localparam int IDX_W = $clog2(N_PORTS);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   logic [N_PORTS-1:0] read_valid_q;

   logic               owner_locked;
   logic               keep_owner;
   logic [N_PORTS-1:0] exclude;
   logic [N_PORTS-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   // lock_cnt counts extra cycles already granted under lock, so the owner sees MAX_LOCK in total.
   assign owner_locked = (state_q == ST_OWNED) && req[owner_q] && lock[owner_q];
   assign keep_owner   = owner_locked && (lock_cnt_q < LOCK_LAST);
   assign exclude      = (owner_locked && !keep_owner) ? grant_q : '0;

   rr_pick #(
      .N_PORTS (N_PORTS),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (req),
      .rr_ptr     (rr_ptr_q),
      .exclude    (exclude),
      .winner_oh  (pick_oh),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         lock_cnt_q   <= '0;
         read_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_cnt_q   <= lock_cnt_d;
         read_valid_q <= grant_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      if (keep_owner) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else if (pick_valid) begin
         state_d    = ST_OWNED;
         owner_d    = pick_idx;
         grant_d    = pick_oh;
         rr_ptr_d   = IDX_W'(wrap_add(int'(pick_idx), 1, N_PORTS));
         lock_cnt_d = '0;
      end else begin
         state_d    = ST_IDLE;
         owner_d    = '0;
         grant_d    = '0;
         lock_cnt_d = '0;
      end
   end

   // A write in the reset cycle is dropped even though grant is still set.
   always_comb begin
      grant          = grant_q;
      read_valid     = read_valid_q;
      mem_read_addr  = '0;
      mem_write_addr = '0;
      mem_write_node = '0;
      mem_write      = 1'b0;
      if (state_q == ST_OWNED) begin
         mem_read_addr  = port_read_addr[bus_offset(int'(owner_q), ADDR_W) +: ADDR_W];
         mem_write_addr = port_write_addr[bus_offset(int'(owner_q), ADDR_W) +: ADDR_W];
         mem_write_node = port_write_node[bus_offset(int'(owner_q), NODE_W) +: NODE_W];
         mem_write      = port_write[owner_q] & ~reset;
      end
   end

   assign read_node = mem_read_node;

endmodule

// File: tb/tb_node_mem_arbiter.sv
// Self-checking bench for node_mem_arbiter: directed table, corner sequences, random vs model.
module tb_node_mem_arbiter;

   localparam int N   = 2;
   localparam int AW  = 5;
   localparam int NW  = 12;
   localparam int ML  = 4;
   localparam int RAW = N * AW;
   localparam int RNW = N * NW;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, lock, port_write, grant, read_valid;
   logic [RAW-1:0] port_read_addr, port_write_addr;
   logic [RNW-1:0] port_write_node;
   logic [NW-1:0]  read_node, mem_write_node, mem_read_node;
   logic [AW-1:0]  mem_read_addr, mem_write_addr;
   logic           mem_write;

   logic [NW-1:0]  mem [32];

   int checks   = 0;
   int failures = 0;

   // reference model: owner/prev owner as port numbers (-1 = none), run = cycles held so far
   int m_owner, m_prev, m_rr, m_run;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] lock;
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_rv;
   } vec_t;

   vec_t tbl [24];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) mem[mem_write_addr] <= mem_write_node;
      mem_read_node <= mem[mem_read_addr];
   end

   node_mem_arbiter #(
      .N_PORTS  (N),
      .ADDR_W   (AW),
      .NODE_W   (NW),
      .MAX_LOCK (ML)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .lock            (lock),
      .port_read_addr  (port_read_addr),
      .port_write_addr (port_write_addr),
      .port_write      (port_write),
      .port_write_node (port_write_node),
      .grant           (grant),
      .read_valid      (read_valid),
      .read_node       (read_node),
      .mem_read_addr   (mem_read_addr),
      .mem_write_addr  (mem_write_addr),
      .mem_write       (mem_write),
      .mem_write_node  (mem_write_node),
      .mem_read_node   (mem_read_node)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] port_bit(input int p);
      if (p < 0) return '0;
      return N'(1) << p;
   endfunction

   // Compare every output against the model in the current cycle.
   task automatic settle();
      logic [AW-1:0] e_ra, e_wa;
      logic [NW-1:0] e_wn;
      logic          e_mw;
      #1;
      e_ra = '0;
      e_wa = '0;
      e_wn = '0;
      e_mw = 1'b0;
      if (m_owner >= 0) begin
         e_ra = port_read_addr[m_owner*AW +: AW];
         e_wa = port_write_addr[m_owner*AW +: AW];
         e_wn = port_write_node[m_owner*NW +: NW];
         e_mw = ((port_write & port_bit(m_owner)) != '0) && !reset;
      end
      chk("grant",          32'(grant),          32'(port_bit(m_owner)));
      chk("read_valid",     32'(read_valid),     32'(port_bit(m_prev)));
      chk("mem_read_addr",  32'(mem_read_addr),  32'(e_ra));
      chk("mem_write_addr", 32'(mem_write_addr), 32'(e_wa));
      chk("mem_write_node", 32'(mem_write_node), 32'(e_wn));
      chk("mem_write",      32'(mem_write),      32'(e_mw));
      chk("grant_onehot0",  32'($onehot0(grant)),      32'd1);
      chk("rv_onehot0",     32'($onehot0(read_valid)), 32'd1);
   endtask

   task automatic model_update();
      int  forced, w, c;
      bit  kept;
      if (reset) begin
         m_owner = -1;
         m_prev  = -1;
         m_rr    = 0;
         m_run   = 0;
      end else begin
         m_prev = m_owner;
         forced = -1;
         kept   = 1'b0;
         if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
            if (m_run < ML) begin
               kept = 1'b1;
               m_run++;
            end else begin
               forced = m_owner;
            end
         end
         if (!kept) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               c = (m_rr + k) % N;
               if (w < 0 && req[c] && c != forced) w = c;
            end
            if (w < 0 && forced >= 0 && req[forced]) w = forced;
            m_owner = w;
            if (w >= 0) begin
               m_rr  = (w + 1) % N;
               m_run = 1;
            end else begin
               m_run = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_write(input int p, input logic [AW-1:0] a, input logic [NW-1:0] d);
      port_write_addr[p*AW +: AW] = a;
      port_write_node[p*NW +: NW] = d;
      req        = port_bit(p);
      port_write = port_bit(p);
      settle();
      tick();
      req = '0;
      settle();
      chk("wr_grant",     32'(grant),          32'(port_bit(p)));
      chk("wr_mem_write", 32'(mem_write),      32'd1);
      chk("wr_addr",      32'(mem_write_addr), 32'(a));
      chk("wr_node",      32'(mem_write_node), 32'(d));
      tick();
      port_write = '0;
      settle();
      chk("wr_release", 32'(grant), 32'd0);
      tick();
   endtask

   task automatic do_read(input int p, input logic [AW-1:0] a, input logic [NW-1:0] d);
      port_read_addr[p*AW +: AW] = a;
      req = port_bit(p);
      settle();
      tick();
      req = '0;
      settle();
      chk("rd_addr", 32'(mem_read_addr), 32'(a));
      tick();
      settle();
      chk("rd_valid", 32'(read_valid), 32'(port_bit(p)));
      chk("rd_node",  32'(read_node),  32'(d));
      tick();
      settle();
      chk("rd_valid_clear", 32'(read_valid), 32'd0);
      tick();
   endtask

   initial begin
      reset           = 1'b1;
      req             = '0;
      lock            = '0;
      port_write      = '0;
      port_read_addr  = '0;
      port_write_addr = '0;
      port_write_node = '0;
      m_owner = -1;
      m_prev  = -1;
      m_rr    = 0;
      m_run   = 0;

      @(negedge clk);
      tick();
      tick();
      settle();
      chk("reset_grant",      32'(grant),      32'd0);
      chk("reset_read_valid", 32'(read_valid), 32'd0);
      tick();
      reset = 1'b0;

      // rows: inputs of this cycle, grant/read_valid seen in this same cycle
      tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00};
      tbl[1]  = '{2'b11, 2'b00, 2'b01, 2'b00};
      tbl[2]  = '{2'b11, 2'b00, 2'b10, 2'b01};
      tbl[3]  = '{2'b11, 2'b00, 2'b01, 2'b10};
      tbl[4]  = '{2'b00, 2'b00, 2'b10, 2'b01};
      tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b10};
      tbl[6]  = '{2'b10, 2'b10, 2'b00, 2'b00};
      tbl[7]  = '{2'b11, 2'b10, 2'b10, 2'b00};
      tbl[8]  = '{2'b11, 2'b10, 2'b10, 2'b10};
      tbl[9]  = '{2'b11, 2'b10, 2'b10, 2'b10};
      tbl[10] = '{2'b11, 2'b10, 2'b10, 2'b10};
      tbl[11] = '{2'b11, 2'b10, 2'b01, 2'b10};
      tbl[12] = '{2'b11, 2'b10, 2'b10, 2'b01};
      tbl[13] = '{2'b00, 2'b00, 2'b10, 2'b10};
      tbl[14] = '{2'b00, 2'b00, 2'b00, 2'b10};
      tbl[15] = '{2'b01, 2'b01, 2'b00, 2'b00};
      tbl[16] = '{2'b01, 2'b01, 2'b01, 2'b00};
      tbl[17] = '{2'b01, 2'b01, 2'b01, 2'b01};
      tbl[18] = '{2'b01, 2'b01, 2'b01, 2'b01};
      tbl[19] = '{2'b01, 2'b01, 2'b01, 2'b01};
      tbl[20] = '{2'b01, 2'b01, 2'b01, 2'b01};
      tbl[21] = '{2'b00, 2'b01, 2'b01, 2'b01};
      tbl[22] = '{2'b00, 2'b00, 2'b00, 2'b01};
      tbl[23] = '{2'b00, 2'b00, 2'b00, 2'b00};

      port_read_addr  = {5'd6, 5'd5};
      port_write_addr = {5'd30, 5'd29};
      port_write_node = {12'h321, 12'h123};
      foreach (tbl[i]) begin
         req  = tbl[i].req;
         lock = tbl[i].lock;
         settle();
         chk($sformatf("tbl%0d_grant", i), 32'(grant),      32'(tbl[i].exp_grant));
         chk($sformatf("tbl%0d_rv", i),    32'(read_valid), 32'(tbl[i].exp_rv));
         tick();
      end
      lock = '0;

      do_write(0, 5'd3, 12'hABC);
      do_write(0, 5'd7, 12'h155);
      do_read(0, 5'd7, 12'h155);
      do_read(1, 5'd3, 12'hABC);

      // non-owner write strobe must not reach memory
      do_write(1, 5'd9, 12'h0F0);
      port_write_addr = {5'd9, 5'd12};
      port_write_node = {12'h777, 12'h222};
      port_write      = 2'b11;
      req             = 2'b01;
      settle();
      tick();
      req = '0;
      settle();
      chk("nonowner_mem_write", 32'(mem_write),      32'd1);
      chk("nonowner_addr",      32'(mem_write_addr), 32'd12);
      chk("nonowner_node",      32'(mem_write_node), 32'h222);
      tick();
      port_write = '0;
      settle();
      tick();
      do_read(1, 5'd9, 12'h0F0);
      do_read(0, 5'd12, 12'h222);

      // reset while port0 owns and writes
      do_write(0, 5'd20, 12'h001);
      port_write_addr[0 +: AW] = 5'd20;
      port_write_node[0 +: NW] = 12'h3C3;
      port_write = 2'b01;
      req        = 2'b01;
      settle();
      tick();
      reset = 1'b1;
      settle();
      chk("rst_cycle_grant",     32'(grant),     32'd1);
      chk("rst_cycle_mem_write", 32'(mem_write), 32'd0);
      tick();
      reset      = 1'b0;
      req        = '0;
      port_write = '0;
      settle();
      chk("rst_grant",      32'(grant),      32'd0);
      chk("rst_read_valid", 32'(read_valid), 32'd0);
      tick();
      req = 2'b11;
      settle();
      tick();
      settle();
      chk("rst_rr_ptr", 32'(grant), 32'd1);
      req = '0;
      tick();
      settle();
      tick();
      do_read(0, 5'd20, 12'h001);

      // random traffic against the model; sticky req/lock so lock runs reach timeout
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req  = N'($urandom);
         if ($urandom_range(0, 3) == 0) lock = ($urandom_range(0, 2) != 0) ? N'($urandom) : '0;
         port_write      = N'($urandom);
         port_read_addr  = RAW'($urandom);
         port_write_addr = RAW'($urandom);
         port_write_node = RNW'($urandom);
         reset           = ($urandom_range(0, 63) == 0);
         settle();
         tick();
      end
      reset      = 1'b0;
      req        = '0;
      lock       = '0;
      port_write = '0;
      settle();
      tick();
      settle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
